// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the load writeback path.
package regfile_pkg;

  localparam int REGADDRWIDTH = 4;
  localparam logic [REGADDRWIDTH-1:0] ZERO_REG = 4'd0;

  // Width of the data field stored in a load queue entry.
  parameter int LOAD_DATA_BITS = 16;

  typedef struct packed {
    logic [REGADDRWIDTH-1:0]   RegAddr;
    logic [LOAD_DATA_BITS-1:0] Data;
    logic                      Spec;
  } load_queue_entry_t;

endpackage

// File: rtl/load_writeback_queue_if.sv
// Load response handshake and register-file load write port.
// master: memory/response side driving Resp*, slave: the writeback queue.
interface load_writeback_queue_if #(
  parameter int DATABITWIDTH = 16
);
  import regfile_pkg::*;

  logic                    RespValid;
  logic                    RespReady;
  logic [REGADDRWIDTH-1:0] RespRegAddr;
  logic [DATABITWIDTH-1:0] RespData;
  logic                    LoadWriteEn;
  logic [REGADDRWIDTH-1:0] LoadWriteRegisterAddr;
  logic [DATABITWIDTH-1:0] LoadWriteData;

  modport master (
    output RespValid, RespRegAddr, RespData,
    input  RespReady, LoadWriteEn, LoadWriteRegisterAddr, LoadWriteData
  );

  modport slave (
    input  RespValid, RespRegAddr, RespData,
    output RespReady, LoadWriteEn, LoadWriteRegisterAddr, LoadWriteData
  );

endinterface

// File: rtl/load_writeback_queue_ctrl.sv
// Pointer, occupancy and speculation-rollback control for the load writeback queue.
// Entries from specStartPtr up to tailPtr are the speculative region; a
// mispredict rewinds tailPtr to specStartPtr and recomputes the count from it.
module load_queue_ctrl #(
  parameter  int QUEUEDEPTH = 4,
  localparam int PTRW       = $clog2(QUEUEDEPTH)
) (
  input  logic            clk,
  input  logic            sync_rst,
  input  logic            clkEn,
  input  logic            speculating,
  input  logic            endPulse,
  input  logic            mispredictPulse,
  input  logic            enqReq,
  input  logic            headSpec,
  output logic            enqWrite,
  output logic            enqSpec,
  output logic            deqFire,
  output logic            clearSpec,
  output logic            full,
  output logic [PTRW-1:0] headPtr,
  output logic [PTRW-1:0] writePtr,
  output logic [PTRW:0]   count
);

  logic [PTRW-1:0] tailPtr;
  logic [PTRW-1:0] specStartPtr;
  logic            specActive;
  logic            rollback;
  logic [PTRW-1:0] headNext;
  logic [PTRW-1:0] tailNext;
  logic [PTRW:0]   countNext;

  assign full      = (count == (PTRW+1)'(QUEUEDEPTH));
  assign deqFire   = clkEn && (count != '0) && !headSpec;
  // A pulse in the same cycle resolves the branch, so the new entry is not speculative.
  assign enqSpec   = speculating && !endPulse && !mispredictPulse;
  // A speculative response arriving with a mispredict belongs to the wrong path.
  assign enqWrite  = clkEn && enqReq && !full && !(mispredictPulse && speculating);
  assign clearSpec = clkEn && (endPulse || mispredictPulse);
  assign rollback  = mispredictPulse && specActive;
  assign writePtr  = rollback ? specStartPtr : tailPtr;

  // Next pointers and occupancy; after a rollback only head..specStart survives.
  always_comb begin
    headNext = headPtr + PTRW'(deqFire);
    tailNext = writePtr + PTRW'(enqWrite);
    if (rollback) begin
      countNext = {1'b0, specStartPtr - headNext} + (PTRW+1)'(enqWrite);
    end else begin
      countNext = count + (PTRW+1)'(enqWrite) - (PTRW+1)'(deqFire);
    end
  end

  // Pointer, count and speculation-region registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      headPtr      <= '0;
      tailPtr      <= '0;
      specStartPtr <= '0;
      count        <= '0;
      specActive   <= 1'b0;
    end else if (clkEn) begin
      headPtr <= headNext;
      tailPtr <= tailNext;
      count   <= countNext;
      if (endPulse || mispredictPulse) begin
        specActive <= 1'b0;
      end else if (enqWrite && enqSpec && !specActive) begin
        specActive   <= 1'b1;
        specStartPtr <= tailPtr;
      end
    end
  end

endmodule

// File: rtl/load_writeback_queue.sv
// In-order load writeback queue between the load response path and the
// register-file load write port. Holds speculative loads until the branch
// resolves, discards them on mispredict, drains one entry per cycle.
// Optional: LOAD_WRITEBACK_BYPASS_EN writes a response straight through
// when the queue is empty and nothing speculative is going on.
module load_writeback_queue #(
  parameter int DATABITWIDTH = 16,
  parameter int QUEUEDEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          clk_en,
  input  logic                          sync_rst,
  input  logic                          Speculating,
  input  logic                          EndSpeculationPulse,
  input  logic                          MispredictedSpeculationPulse,
  load_writeback_queue_if.slave         bus,
  output logic [$clog2(QUEUEDEPTH):0]   QueueOccupancy
);
  import regfile_pkg::*;

  localparam int PTRW = $clog2(QUEUEDEPTH);

  load_queue_entry_t entries [QUEUEDEPTH];

  logic            enqReq;
  logic            enqWrite;
  logic            enqSpec;
  logic            deqFire;
  logic            clearSpec;
  logic            full;
  logic            bypassFire;
  logic [PTRW-1:0] headPtr;
  logic [PTRW-1:0] writePtr;
  logic [PTRW:0]   count;

`ifdef LOAD_WRITEBACK_BYPASS_EN
  assign bypassFire = clk_en && bus.RespValid && !Speculating &&
                      (bus.RespRegAddr != ZERO_REG) && (count == '0) &&
                      !EndSpeculationPulse && !MispredictedSpeculationPulse;
`else
  assign bypassFire = 1'b0;
`endif

  // Writes to the zero register complete the handshake but are never stored.
  assign enqReq         = bus.RespValid && (bus.RespRegAddr != ZERO_REG) && !bypassFire;
  assign bus.RespReady  = !full;
  assign QueueOccupancy = count;

  load_queue_ctrl #(
    .QUEUEDEPTH (QUEUEDEPTH)
  ) u_ctrl (
    .clk             (clk),
    .sync_rst        (sync_rst),
    .clkEn           (clk_en),
    .speculating     (Speculating),
    .endPulse        (EndSpeculationPulse),
    .mispredictPulse (MispredictedSpeculationPulse),
    .enqReq          (enqReq),
    .headSpec        (entries[headPtr].Spec),
    .enqWrite        (enqWrite),
    .enqSpec         (enqSpec),
    .deqFire         (deqFire),
    .clearSpec       (clearSpec),
    .full            (full),
    .headPtr         (headPtr),
    .writePtr        (writePtr),
    .count           (count)
  );

  // Entry storage: resolve clears speculation marks, then the new entry lands.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < QUEUEDEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (clk_en) begin
      if (clearSpec) begin
        for (int i = 0; i < QUEUEDEPTH; i++) begin
          entries[i].Spec <= 1'b0;
        end
      end
      if (enqWrite) begin
        entries[writePtr] <= '{RegAddr: bus.RespRegAddr, Data: bus.RespData, Spec: enqSpec};
      end
    end
  end

  // Register-file write port: bypassed response, else the draining head, else idle zeros.
  always_comb begin
    bus.LoadWriteEn           = bypassFire || deqFire;
    bus.LoadWriteRegisterAddr = ZERO_REG;
    bus.LoadWriteData         = '0;
    if (bypassFire) begin
      bus.LoadWriteRegisterAddr = bus.RespRegAddr;
      bus.LoadWriteData         = bus.RespData;
    end else if (deqFire) begin
      bus.LoadWriteRegisterAddr = entries[headPtr].RegAddr;
      bus.LoadWriteData         = entries[headPtr].Data;
    end
  end

endmodule

// File: tb/tb_load_writeback_queue.sv
// Scoreboard bench for load_writeback_queue: stimulus pushes expected
// register writes, a negedge monitor pops and compares every LoadWriteEn.
module tb_load_writeback_queue;
  import regfile_pkg::*;

`ifdef LOAD_WRITEBACK_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_en;
  logic       sync_rst;
  logic       Speculating;
  logic       EndSpeculationPulse;
  logic       MispredictedSpeculationPulse;
  logic [2:0] QueueOccupancy;

  int checks = 0;
  int errors = 0;
  logic [19:0] expQ[$];

  load_writeback_queue_if #(.DATABITWIDTH(16)) bus ();

  load_writeback_queue #(.DATABITWIDTH(16), .QUEUEDEPTH(4)) dut (
    .clk                          (clk),
    .clk_en                       (clk_en),
    .sync_rst                     (sync_rst),
    .Speculating                  (Speculating),
    .EndSpeculationPulse          (EndSpeculationPulse),
    .MispredictedSpeculationPulse (MispredictedSpeculationPulse),
    .bus                          (bus),
    .QueueOccupancy               (QueueOccupancy)
  );

  always #5 clk = ~clk;

  // Monitor: every register write must match the oldest expected write.
  always @(negedge clk) begin
    logic [19:0] e;
    if (bus.LoadWriteEn === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got addr=%0d data=%h required no write",
                 bus.LoadWriteRegisterAddr, bus.LoadWriteData);
      end else begin
        e = expQ.pop_front();
        if ({bus.LoadWriteRegisterAddr, bus.LoadWriteData} !== e) begin
          errors++;
          $display("FAIL wb_entry got addr=%0d data=%h required addr=%0d data=%h",
                   bus.LoadWriteRegisterAddr, bus.LoadWriteData, e[19:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic resp(input logic [3:0] a, input logic [15:0] d, input bit expectWrite);
    bus.RespValid   = 1'b1;
    bus.RespRegAddr = a;
    bus.RespData    = d;
    if (expectWrite) expQ.push_back({a, d});
  endtask

  initial begin
    clk_en = 1'b1; sync_rst = 1'b1; Speculating = 1'b0;
    EndSpeculationPulse = 1'b0; MispredictedSpeculationPulse = 1'b0;
    bus.RespValid = 1'b0; bus.RespRegAddr = '0; bus.RespData = '0;
    step(); step();
    sync_rst = 1'b0;

    // Reset state
    mid();
    chk("rst_ready", 32'(bus.RespReady), 32'd1);
    chk("rst_we",    32'(bus.LoadWriteEn), 32'd0);
    chk("rst_addr",  32'(bus.LoadWriteRegisterAddr), 32'd0);
    chk("rst_data",  32'(bus.LoadWriteData), 32'd0);
    chk("rst_occ",   32'(QueueOccupancy), 32'd0);
    step();

    // Single non-speculative load, 1-cycle latency through the queue
    resp(4'd3, 16'h1234, 1'b1);
    mid(); chk("t1_same_cycle_we", 32'(bus.LoadWriteEn), 32'(BYP));
    step();
    bus.RespValid = 1'b0;
    mid(); chk("t1_next_we", 32'(bus.LoadWriteEn), 32'(!BYP));
           chk("t1_next_occ", 32'(QueueOccupancy), 32'(!BYP));
    step();
    mid(); chk("t1_occ_final", 32'(QueueOccupancy), 32'd0);
    step();

    // Fill with speculative entries, fifth response held, then drain in order
    Speculating = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resp(4'(4 + i), 16'hA000 + 16'(i), 1'b1);
      step();
    end
    resp(4'd8, 16'hA004, 1'b1);
    mid(); chk("t2_full_ready", 32'(bus.RespReady), 32'd0);
           chk("t2_full_occ", 32'(QueueOccupancy), 32'd4);
           chk("t2_stall_we", 32'(bus.LoadWriteEn), 32'd0);
    step();
    Speculating = 1'b0; EndSpeculationPulse = 1'b1;
    mid(); chk("t2_pulse_we", 32'(bus.LoadWriteEn), 32'd0);
    step();
    EndSpeculationPulse = 1'b0;
    mid(); chk("t2_drain0_we", 32'(bus.LoadWriteEn), 32'd1);
           chk("t2_drain0_ready", 32'(bus.RespReady), 32'd0);
    step();
    mid(); chk("t2_drain1_we", 32'(bus.LoadWriteEn), 32'd1);
           chk("t2_drain1_ready", 32'(bus.RespReady), 32'd1);
    step();
    bus.RespValid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      mid(); chk($sformatf("t2_drain%0d_we", k), 32'(bus.LoadWriteEn), 32'd1);
      step();
    end
    mid(); chk("t2_idle_we", 32'(bus.LoadWriteEn), 32'd0);
           chk("t2_idle_occ", 32'(QueueOccupancy), 32'd0);
    step();

    // Mispredict rolls back r2/r5 and a same-cycle speculative r6
    resp(4'd1, 16'h0011, 1'b1);
    mid(); chk("t3_r1_same_we", 32'(bus.LoadWriteEn), 32'(BYP));
    step();
    Speculating = 1'b1;
    resp(4'd2, 16'h0022, 1'b0);
    mid(); chk("t3_r1_next_we", 32'(bus.LoadWriteEn), 32'(!BYP));
    step();
    resp(4'd5, 16'h0055, 1'b0);
    step();
    resp(4'd6, 16'h0066, 1'b0);
    MispredictedSpeculationPulse = 1'b1;
    mid(); chk("t3_occ_before", 32'(QueueOccupancy), 32'd2);
    step();
    MispredictedSpeculationPulse = 1'b0; Speculating = 1'b0;
    resp(4'd9, 16'h0099, 1'b1);
    mid(); chk("t3_occ_after", 32'(QueueOccupancy), 32'd0);
           chk("t3_r9_same_we", 32'(bus.LoadWriteEn), 32'(BYP));
    step();
    bus.RespValid = 1'b0;
    mid(); chk("t3_r9_next_we", 32'(bus.LoadWriteEn), 32'(!BYP));
    step();
    mid(); chk("t3_occ_final", 32'(QueueOccupancy), 32'd0);
    step();

    // Mispredict and End together: mispredict wins
    Speculating = 1'b1;
    resp(4'd10, 16'h00AA, 1'b0); step();
    resp(4'd11, 16'h00BB, 1'b0); step();
    bus.RespValid = 1'b0; Speculating = 1'b0;
    MispredictedSpeculationPulse = 1'b1; EndSpeculationPulse = 1'b1;
    mid(); chk("t4_occ_before", 32'(QueueOccupancy), 32'd2);
    step();
    MispredictedSpeculationPulse = 1'b0; EndSpeculationPulse = 1'b0;
    mid(); chk("t4_occ_after", 32'(QueueOccupancy), 32'd0);
           chk("t4_we", 32'(bus.LoadWriteEn), 32'd0);
    step(); step();

    // Zero-register response, then clk_en gating of a pending entry
    resp(4'd0, 16'hDEAD, 1'b0);
    mid(); chk("t5_zero_ready", 32'(bus.RespReady), 32'd1);
    step();
    bus.RespValid = 1'b0;
    mid(); chk("t5_zero_occ", 32'(QueueOccupancy), 32'd0);
           chk("t5_zero_we", 32'(bus.LoadWriteEn), 32'd0);
    step();
    Speculating = 1'b1;
    resp(4'd12, 16'h0CCC, 1'b1);
    step();
    bus.RespValid = 1'b0; Speculating = 1'b0; EndSpeculationPulse = 1'b1;
    step();
    EndSpeculationPulse = 1'b0; clk_en = 1'b0;
    resp(4'd13, 16'h0DDD, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mid(); chk($sformatf("t5_gated%0d_we", k), 32'(bus.LoadWriteEn), 32'd0);
             chk($sformatf("t5_gated%0d_occ", k), 32'(QueueOccupancy), 32'd1);
      step();
    end
    bus.RespValid = 1'b0; clk_en = 1'b1;
    mid(); chk("t5_resume_we", 32'(bus.LoadWriteEn), 32'd1);
    step();
    mid(); chk("t5_occ_final", 32'(QueueOccupancy), 32'd0);
    step();

    // Empty-queue write-through (when built in), speculative response always queued
    resp(4'd7, 16'hBEEF, 1'b1);
    mid(); chk("t6_same_we", 32'(bus.LoadWriteEn), 32'(BYP));
    step();
    Speculating = 1'b1;
    resp(4'd7, 16'h0F0F, 1'b1);
    mid(); chk("t6_spec_cycle_we", 32'(bus.LoadWriteEn), 32'(!BYP));
           chk("t6_spec_cycle_occ", 32'(QueueOccupancy), 32'(!BYP));
    step();
    bus.RespValid = 1'b0; Speculating = 1'b0; EndSpeculationPulse = 1'b1;
    mid(); chk("t6_queued_occ", 32'(QueueOccupancy), 32'd1);
           chk("t6_queued_we", 32'(bus.LoadWriteEn), 32'd0);
    step();
    EndSpeculationPulse = 1'b0;
    mid(); chk("t6_drain_we", 32'(bus.LoadWriteEn), 32'd1);
    step();
    mid(); chk("t6_occ_final", 32'(QueueOccupancy), 32'd0);
    step(); step();

    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_writeback_queue.md
Name: load_writeback_queue

Overview:
- In-order buffer between the data-memory load response path and the register file's load write port (LoadWriteEn/Addr/Data).
- Accepts load results tagged with a destination register and holds them while speculation is unresolved.
- Discards entries on mispredict and drains one committed entry per cycle into the register file.

Parameters:
- DATABITWIDTH, 16, width of load data and register contents.
- QUEUEDEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- clk_en  in  1  global clock enable; when low, no state changes and LoadWriteEn=0.
- sync_rst  in  1  synchronous, active-high reset.
- Speculating  in  1  processor is executing past an unresolved branch.
- EndSpeculationPulse  in  1  one-cycle pulse; branch resolved correct.
- MispredictedSpeculationPulse  in  1  one-cycle pulse; branch resolved wrong.
- RespValid  in  1  load response present.
- RespReady  out  1  queue can accept; equals !Full.
- RespRegAddr  in  4  destination register.
- RespData  in  DATABITWIDTH  load result.
- LoadWriteEn  out  1  write strobe to register file.
- LoadWriteRegisterAddr  out  4  write address.
- LoadWriteData  out  DATABITWIDTH  write data.
- QueueOccupancy  out  $clog2(QUEUEDEPTH)+1  valid entry count.

Behaviour:
- Storage: circular buffer of {RegAddr[3:0], Data, Spec}. Pointers: HeadPtr, TailPtr, SpecStartPtr. Flags: SpecActive. Counter: Count.
- Reset: all pointers and Count = 0, SpecActive = 0, all Spec bits = 0; outputs RespReady=1, LoadWriteEn=0, Addr=0, Data=0, QueueOccupancy=0.
- Enqueue:
  - Occurs when RespValid && RespReady && clk_en.
  - RespRegAddr==0 (zero register): handshake completes, nothing is stored.
  - Otherwise the entry is written at TailPtr with Spec=Speculating, TailPtr++, Count++.
  - On the first speculative enqueue while SpecActive==0: SpecStartPtr=TailPtr, SpecActive=1.
- Dequeue:
  - Condition: Count!=0 && head Spec==0 && clk_en.
  - LoadWriteEn=1 that cycle (combinational from head); Addr/Data driven from head; HeadPtr++, Count--.
  - Latency: a non-speculative entry accepted in cycle N appears on LoadWriteEn in cycle N+1 at the earliest.
  - A speculative entry at the head stalls the drain.
- EndSpeculationPulse: clears every Spec bit and sets SpecActive=0. An entry enqueued in the same cycle is stored with Spec=0.
- MispredictedSpeculationPulse:
  - If SpecActive: TailPtr=SpecStartPtr, Count reduced by the number of discarded entries, SpecActive=0.
  - A speculative enqueue in the same cycle is also discarded.
  - A non-speculative dequeue in the same cycle still completes.
- Mispredict and End in the same cycle: mispredict wins.
- Nested speculation is not supported; Speculating is a single level.
- Simultaneous enqueue and dequeue: Count unchanged, both pointers advance.
- Full: RespReady=0; no bypass into a full queue, even when a dequeue happens the same cycle.
- Pointer wrap-around: modulo QUEUEDEPTH.
- sync_rst mid-drain: the queue empties and LoadWriteEn=0 the next cycle.

Optional Feature:
- Macro: LOAD_WRITEBACK_BYPASS_EN.
- Defined: when Count==0, RespValid, !Speculating, RespRegAddr!=0, clk_en, and no pulse is active, the response is written through in the same cycle (LoadWriteEn=1, Addr/Data from Resp*) and is not enqueued.
- Undefined: every response goes through the queue, giving the 1-cycle minimum latency.

Decomposition:
- Shared package regfile_pkg:
  - REGADDRWIDTH=4, ZERO_REG=4'd0.
  - Typedef load_queue_entry_t {RegAddr, Data, Spec}, parameterised by DATABITWIDTH via package parameter.
- Sub-module load_queue_ctrl: pointers, Count, SpecStartPtr and speculation rollback; storage and output muxing stay in the top.

Test Plan:
- Reset, then enqueue {r3, 16'h1234} non-speculative -> next cycle LoadWriteEn=1, Addr=3, Data=16'h1234; QueueOccupancy returns to 0.
- Enqueue 4 entries with drain blocked by a speculative head -> RespReady=0 at Count=4; fifth RespValid held; after EndSpeculationPulse, entries drain in order on 4 consecutive cycles.
- Non-speculative r1, then Speculating=1 with r2 and r5 enqueued, then MispredictedSpeculationPulse -> only r1 is written; Count=0; TailPtr equals the original SpecStartPtr.
- Same-cycle MispredictedSpeculationPulse and EndSpeculationPulse with 2 speculative entries -> both discarded, no LoadWriteEn.
- Enqueue with RespRegAddr=0 -> RespReady handshake completes, Count stays 0, no LoadWriteEn. Then with clk_en=0 for 3 cycles while an entry is pending -> no write until clk_en returns.
- With LOAD_WRITEBACK_BYPASS_EN defined and the queue empty: {r7, 16'hBEEF} -> LoadWriteEn=1 in the same cycle, Count stays 0; with Speculating=1 the response is queued instead.
